// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the D-stage hazard scoreboard.
// Slot fields are sized for the widest supported configuration (up to 256
// registers, 4-bit Tnew); narrower instances zero-extend into them.
package hazard_pkg;

  localparam int TW_DEF   = 2;
  localparam int SLOT_RAW = 8;
  localparam int SLOT_TW  = 4;

  // One in-flight instruction tracked after D.
  typedef struct packed {
    logic                valid;
    logic [SLOT_RAW-1:0] dst;
    logic [SLOT_TW-1:0]  tnew;
  } slot_t;

  // Forward-select encoding: register file, or slot index + 1.
  localparam int FWD_RF = 0;
  localparam int FWD_E  = 1;
  localparam int FWD_M  = 2;
  localparam int FWD_W  = 3;

  // Tnew countdown that holds at zero once the result is available.
  function automatic logic [SLOT_TW-1:0] satDec(input logic [SLOT_TW-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: compares one D-stage source operand against all tracked
// slots. The youngest matching writer decides both the stall and the
// forward select; register 0 never matches.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int RAW   = 5,
  parameter int TW    = TW_DEF,
  parameter int SELW  = 2
) (
  input  logic                    en,
  input  logic [RAW-1:0]          operand,
  input  logic [TW-1:0]           tuse,
  input  slot_t [DEPTH-1:0]       slots,
  output logic                    stall,
  output logic [SELW-1:0]         fwdSel
);

  logic [DEPTH-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gHit
      assign hit[gi] = en && (operand != '0) && slots[gi].valid &&
                       (slots[gi].dst != '0) &&
                       (slots[gi].dst == SLOT_RAW'(operand));
    end
  endgenerate

  // Walk oldest to youngest so the lowest-index hit overrides older ones.
  always_comb begin
    stall  = 1'b0;
    fwdSel = SELW'(FWD_RF);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        stall  = slots[k].tnew > SLOT_TW'(tuse);
        fwdSel = (slots[k].tnew == '0) ? SELW'(FWD_E + k) : SELW'(FWD_RF);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall and forwarding unit for the in-order
// pipeline. Tracks destination/Tnew of instructions in E, M, W and compares
// them with the Tuse of the instruction in D.
// Optional: define HAZARD_MD_EN to build the mult/div busy counter and its
// HI/LO stall; otherwise md_busy is 0 and the md_* inputs are ignored.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int DEPTH    = 3,
  parameter int TW       = TW_DEF,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rs_en,
  input  logic                       rt_en,
  input  logic [$clog2(NREG)-1:0]    rs,
  input  logic [$clog2(NREG)-1:0]    rt,
  input  logic [TW-1:0]              tuse_rs,
  input  logic [TW-1:0]              tuse_rt,
  input  logic                       wr_en,
  input  logic [$clog2(NREG)-1:0]    wr_dst,
  input  logic [TW-1:0]              tnew,
  input  logic                       flush,
  input  logic                       md_start,
  input  logic                       md_is_div,
  input  logic                       md_use,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rs,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rt,
  output logic                       md_busy
);

  localparam int RAW  = $clog2(NREG);
  localparam int SELW = $clog2(DEPTH + 1);

  slot_t [DEPTH-1:0] slotsReg;
  slot_t [DEPTH-1:0] slotsNext;
  logic              rsStall;
  logic              rtStall;
  logic              regStall;

  // Advance the pipeline shadow: age each slot, admit D unless stalled.
  always_comb begin
    slotsNext = '0;
    if (!flush) begin
      for (int k = 1; k < DEPTH; k++) begin
        slotsNext[k].valid = slotsReg[k-1].valid;
        slotsNext[k].dst   = slotsReg[k-1].dst;
        slotsNext[k].tnew  = satDec(slotsReg[k-1].tnew);
      end
      if (!stall && wr_en) begin
        slotsNext[0].valid = 1'b1;
        slotsNext[0].dst   = SLOT_RAW'(wr_dst);
        slotsNext[0].tnew  = SLOT_TW'(tnew);
      end
    end
  end

  // Slot state register; reset leaves every slot empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotsReg <= '0;
    end else begin
      slotsReg <= slotsNext;
    end
  end

  hazard_match #(.DEPTH(DEPTH), .RAW(RAW), .TW(TW), .SELW(SELW)) uMatchRs (
    .en(rs_en), .operand(rs), .tuse(tuse_rs), .slots(slotsReg),
    .stall(rsStall), .fwdSel(fwd_rs)
  );

  hazard_match #(.DEPTH(DEPTH), .RAW(RAW), .TW(TW), .SELW(SELW)) uMatchRt (
    .en(rt_en), .operand(rt), .tuse(tuse_rt), .slots(slotsReg),
    .stall(rtStall), .fwdSel(fwd_rt)
  );

  assign regStall = rsStall | rtStall;

`ifdef HAZARD_MD_EN
  localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int MDW    = $clog2(MAXLAT + 1);

  logic [MDW-1:0] mdCntReg;
  logic           mdIssuedReg;
  logic           mdStall;

  // HI/LO is unavailable while the unit counts down or was just started.
  assign mdStall = md_use && ((mdCntReg != '0) || mdIssuedReg);

  // Busy counter: loads on an accepted start, otherwise counts to zero.
  // Flush leaves it alone since an issued mult/div always completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdCntReg    <= '0;
      mdIssuedReg <= 1'b0;
    end else if (md_start && !stall) begin
      mdCntReg    <= md_is_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
      mdIssuedReg <= 1'b1;
    end else begin
      mdCntReg    <= (mdCntReg == '0) ? mdCntReg : mdCntReg - 1'b1;
      mdIssuedReg <= 1'b0;
    end
  end

  assign md_busy = (mdCntReg != '0);
  assign stall   = regStall | mdStall;
`else
  localparam int unusedLat = MULT_LAT + DIV_LAT;
  logic unusedMd;
  assign unusedMd = ^{md_start, md_is_div, md_use};
  assign md_busy  = 1'b0;
  assign stall    = regStall;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard. The reference model keeps a list
// of issued writers with the edge at which they entered E, and derives the
// stage and remaining Tnew arithmetically from the current cycle number.
module tb_hazard_scoreboard;

  localparam int DEPTH    = 3;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rs_en = 1'b0, rt_en = 1'b0;
  logic [4:0] rs = '0, rt = '0, wr_dst = '0;
  logic [1:0] tuse_rs = '0, tuse_rt = '0, tnew = '0;
  logic       wr_en = 1'b0, flush = 1'b0;
  logic       md_start = 1'b0, md_is_div = 1'b0, md_use = 1'b0;
  logic       stall, md_busy;
  logic [1:0] fwd_rs, fwd_rt;

  hazard_scoreboard #(.NREG(32), .DEPTH(DEPTH), .TW(2),
                      .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .rs_en(rs_en), .rt_en(rt_en), .rs(rs), .rt(rt),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .wr_en(wr_en), .wr_dst(wr_dst),
    .tnew(tnew), .flush(flush), .md_start(md_start), .md_is_div(md_is_div),
    .md_use(md_use), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit rsE; int rs; int tuseRs; bit rtE; int rt; int tuseRt;
    bit wrE; int dst; int tn; bit fl; bit mdS; bit mdD; bit mdU;
  } din_t;

  typedef struct { int dst; int tnew; int e; } rec_t;
  typedef struct { int st; int fwdRs; int fwdRt; int busy; int cyc; } exp_t;

  rec_t recs[$];
  exp_t expQ[$];
  int   cyc = 0;
  int   lastFlush = -1;
  int   mdEnd = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   stimDone = 0;

  function automatic din_t idle();
    din_t d;
    d = '{rst:1, rsE:0, rs:0, tuseRs:0, rtE:0, rt:0, tuseRt:0,
          wrE:0, dst:0, tn:0, fl:0, mdS:0, mdD:0, mdU:0};
    return d;
  endfunction

  // Youngest live writer of op decides stall and forward select.
  function automatic void matchOp(input bit en, input int op, input int tuse,
                                  output int st, output int fwd);
    int best = DEPTH;
    int rem = 0;
    st = 0; fwd = 0;
    if (!en || op == 0) return;
    foreach (recs[i]) begin
      int stage = cyc - recs[i].e;
      if (recs[i].dst == op && recs[i].e > lastFlush &&
          stage >= 0 && stage < DEPTH && stage < best) begin
        best = stage;
        rem  = (recs[i].tnew > stage) ? recs[i].tnew - stage : 0;
      end
    end
    if (best < DEPTH) begin
      st  = (rem > tuse) ? 1 : 0;
      fwd = (rem == 0) ? best + 1 : 0;
    end
  endfunction

  task automatic step(input din_t d);
    exp_t x;
    int   sRs, sRt, mdSt;
    @(negedge clk);
    rst_n = d.rst; rs_en = d.rsE; rs = 5'(d.rs); tuse_rs = 2'(d.tuseRs);
    rt_en = d.rtE; rt = 5'(d.rt); tuse_rt = 2'(d.tuseRt);
    wr_en = d.wrE; wr_dst = 5'(d.dst); tnew = 2'(d.tn); flush = d.fl;
    md_start = d.mdS; md_is_div = d.mdD; md_use = d.mdU;
    if (!d.rst) begin
      recs.delete();
      mdEnd = 0;
    end
    matchOp(d.rsE, d.rs, d.tuseRs, sRs, x.fwdRs);
    matchOp(d.rtE, d.rt, d.tuseRt, sRt, x.fwdRt);
    mdSt = 0;
    x.busy = 0;
`ifdef HAZARD_MD_EN
    x.busy = (cyc < mdEnd) ? 1 : 0;
    mdSt   = (d.mdU && x.busy != 0) ? 1 : 0;
`endif
    x.st  = (sRs != 0 || sRt != 0 || mdSt != 0) ? 1 : 0;
    x.cyc = cyc;
    expQ.push_back(x);
    // Effect of the coming rising edge.
    if (d.rst) begin
      if (d.fl) lastFlush = cyc + 1;
      else if (d.wrE && x.st == 0) recs.push_back('{dst:d.dst, tnew:d.tn, e:cyc + 1});
`ifdef HAZARD_MD_EN
      if (d.mdS && x.st == 0) mdEnd = cyc + 1 + (d.mdD ? DIV_LAT : MULT_LAT);
`endif
    end
    cyc++;
    while (recs.size() > 0 && cyc - recs[0].e > DEPTH + 1) void'(recs.pop_front());
  endtask

  task automatic chk(input string name, input int got, input int want, input int c);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s cyc %0d: got %0d expected %0d", name, c, got, want);
    end
  endtask

  // Monitor: DUT outputs are valid every cycle; compare away from the edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        x = expQ.pop_front();
        chk("stall",   int'(stall),   x.st,    x.cyc);
        chk("fwd_rs",  int'(fwd_rs),  x.fwdRs, x.cyc);
        chk("fwd_rt",  int'(fwd_rt),  x.fwdRt, x.cyc);
        chk("md_busy", int'(md_busy), x.busy,  x.cyc);
        $display("cyc %0d stall=%0d fwd_rs=%0d fwd_rt=%0d md_busy=%0d",
                 x.cyc, stall, fwd_rs, fwd_rt, md_busy);
      end
    end
  end

  // Stimulus: reset, random traffic with a mid-run reset, then directed cases.
  initial begin
    din_t d;
    for (int i = 0; i < 3; i++) begin
      d = idle(); d.rst = 0; d.rsE = 1; d.rs = 8; d.wrE = 1; d.dst = 8; d.tn = 3;
      d.mdS = 1; d.mdU = 1;
      step(d);
    end
    for (int i = 0; i < 400; i++) begin
      d = idle();
      d.rst    = !(i == 200 || i == 201);
      d.rsE    = $urandom_range(0, 1);
      d.rs     = $urandom_range(0, 4);
      d.tuseRs = $urandom_range(0, 3);
      d.rtE    = $urandom_range(0, 1);
      d.rt     = $urandom_range(0, 4);
      d.tuseRt = $urandom_range(0, 3);
      d.wrE    = ($urandom_range(0, 9) < 7);
      d.dst    = $urandom_range(0, 4);
      d.tn     = $urandom_range(0, 3);
      d.fl     = ($urandom_range(0, 19) == 0);
      d.mdS    = ($urandom_range(0, 11) == 0);
      d.mdD    = $urandom_range(0, 1);
      d.mdU    = d.mdS || ($urandom_range(0, 9) == 0);
      step(d);
    end
    // add r8 (tnew 0), then a reader with tuse 1.
    d = idle(); d.wrE = 1; d.dst = 8; d.tn = 0; step(d);
    d = idle(); d.rsE = 1; d.rs = 8; d.tuseRs = 1; step(d);
    // lw r9 (tnew 2), then beq held in D while stalled.
    d = idle(); d.wrE = 1; d.dst = 9; d.tn = 2; step(d);
    for (int i = 0; i < 4; i++) begin
      d = idle(); d.rsE = 1; d.rs = 9; d.tuseRs = 0; step(d);
    end
    // Two writers of r10 in flight; youngest wins.
    d = idle(); d.wrE = 1; d.dst = 10; d.tn = 0; step(d);
    step(d);
    d = idle(); d.rtE = 1; d.rt = 10; d.tuseRt = 0; step(d);
    // Write to r0 never matches.
    d = idle(); d.wrE = 1; d.dst = 0; d.tn = 3; step(d);
    d = idle(); d.rsE = 1; d.rs = 0; d.rtE = 1; d.rt = 0; step(d);
    // Flush while lw r9 is in E, with a stalled reader in D.
    d = idle(); d.wrE = 1; d.dst = 9; d.tn = 2; step(d);
    d = idle(); d.fl = 1; d.rsE = 1; d.rs = 9; step(d);
    d = idle(); d.rsE = 1; d.rs = 9; step(d);
    // div then mflo, then mult then mflo.
    d = idle(); d.mdS = 1; d.mdD = 1; d.mdU = 1; step(d);
    for (int i = 0; i < 12; i++) begin
      d = idle(); d.mdU = 1; step(d);
    end
    d = idle(); d.mdS = 1; d.mdD = 0; d.mdU = 1; step(d);
    for (int i = 0; i < 7; i++) begin
      d = idle(); d.mdU = 1; step(d);
    end
    d = idle(); step(d);
    stimDone = 1;
  end

  // Drain the scoreboard and report.
  initial begin
    wait (stimDone);
    repeat (3) @(negedge clk);
    #3;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
